// File: rtl/fifo_salida_mux_pkg.sv
// Shared constants for the output buffer stage placed after the memory mux.
package fifo_salida_mux_pkg;

    // Word width shared with the mux data_out.
    localparam int unsigned DATA_WIDTH = 2;
    // Number of entries. This must be a power of two so that the pointers wrap naturally.
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ADDR_WIDTH = 2;
    // The occupancy counter needs one bit more than the pointers so it can represent DEPTH.
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    localparam int unsigned ALMOST_FULL_TH_DEF = 3;
    localparam int unsigned ALMOST_EMPTY_TH_DEF = 1;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

endpackage

// File: rtl/fifo_salida_mux_if.sv
// Push/pop handshake and status bundle between the mux side and the downstream reader.
interface fifo_salida_mux_if;
    import fifo_salida_mux_pkg::*;

    data_t data_in;
    logic  push;
    logic  pop;
    data_t data_out;
    logic  valid_out;
    logic  full;
    logic  empty;
    logic  almost_full;
    logic  almost_empty;
    logic  fifo_error;
    cnt_t  count;

    // Producer/consumer side: drives requests and observes status.
    modport master (
        output data_in, push, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty, fifo_error, count
    );

    // FIFO side.
    modport slave (
        input  data_in, push, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty, fifo_error, count
    );

endinterface

// File: rtl/fifo_salida_mux_memoria_fifo.sv
// DEPTH x DATA_WIDTH register file: synchronous write port, combinational read port.
module memoria_fifo
    import fifo_salida_mux_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  addr_t raddr,
    output data_t rdata
);

    data_t mem [DEPTH];

    // Storage is not reset. Occupancy tracking makes any stale contents unobservable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_salida_mux.sv
// Output buffer FIFO. It holds the pointers, the occupancy count, the flags and the registered
// read word.
module fifo_salida_mux
    import fifo_salida_mux_pkg::*;
#(
    parameter int unsigned ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
    parameter int unsigned ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
    input logic               clk,
    input logic               reset_L,
    fifo_salida_mux_if.slave  bus
);

    addr_t wr_ptr_q, wr_ptr_d;
    addr_t rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    data_t data_out_q, data_out_d;
    logic  valid_q, valid_d;
    logic  error_q, error_d;
    logic  empty, full;
    logic  push_ok, pop_ok;
    data_t rdata;

    memoria_fifo u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_t'(DEPTH));

    // Acceptance and next state. A pop on a full FIFO frees a slot for a push in the same edge.
    // There is no bypass, so a push into an empty FIFO is never visible to a same-cycle pop.
    always_comb begin
        pop_ok     = bus.pop && !empty;
        push_ok    = bus.push && (!full || pop_ok);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = pop_ok;
        error_d    = error_q | (bus.push & ~push_ok) | (bus.pop & empty);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + addr_t'(1);
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + addr_t'(1);
            data_out_d = rdata;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers. Reset clears the registers immediately and discards all queued data.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= cnt_t'(ALMOST_FULL_TH));
    assign bus.almost_empty = (count_q <= cnt_t'(ALMOST_EMPTY_TH));
    assign bus.fifo_error   = error_q;
    assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_salida_mux.sv
// Bench for fifo_salida_mux. A queue-based reference model covers directed and random traffic.
module tb_fifo_salida_mux;
    import fifo_salida_mux_pkg::*;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int total = 0;
    int bad = 0;

    // Reference model state.
    data_t m_q[$];
    data_t m_dout;
    logic  m_vout;
    logic  m_err;

    fifo_salida_mux_if bus ();

    fifo_salida_mux dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = m_q.size();
        check({tag, ".count"}, int'(bus.count), n);
        check({tag, ".full"}, int'(bus.full), int'(n == DEPTH));
        check({tag, ".empty"}, int'(bus.empty), int'(n == 0));
        check({tag, ".almost_full"}, int'(bus.almost_full), int'(n >= ALMOST_FULL_TH_DEF));
        check({tag, ".almost_empty"}, int'(bus.almost_empty), int'(n <= ALMOST_EMPTY_TH_DEF));
        check({tag, ".fifo_error"}, int'(bus.fifo_error), int'(m_err));
        check({tag, ".data_out"}, int'(bus.data_out), int'(m_dout));
        check({tag, ".valid_out"}, int'(bus.valid_out), int'(m_vout));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = '0;
        m_vout = 1'b0;
        m_err  = 1'b0;
    endtask

    // Called at posedge+1. It drives the inputs for one cycle, advances the model at the edge
    // and checks #1 later.
    task automatic cycle(input logic push, input logic pop, input data_t din, input string tag);
        bit pop_ok, push_ok;
        bus.push    = push;
        bus.pop     = pop;
        bus.data_in = din;
        @(posedge clk);
        pop_ok  = pop && (m_q.size() > 0);
        push_ok = push && ((m_q.size() < DEPTH) || pop_ok);
        if ((push && !push_ok) || (pop && m_q.size() == 0)) m_err = 1'b1;
        m_vout = pop_ok;
        if (pop_ok) m_dout = m_q.pop_front();
        if (push_ok) m_q.push_back(din);
        #1;
        check_all(tag);
    endtask

    // Asserts reset mid-cycle, checks the clear before any edge, holds for two edges and
    // then releases.
    task automatic do_reset(input string tag);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset_L = 1'b1;
    endtask

    initial begin
        data_t fill_a[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        data_t fill_b[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        model_reset();

        // Power-on reset held for two cycles.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("por");
        reset_L = 1'b1;
        cycle(1'b0, 1'b0, 2'b00, "idle");

        // Fill the FIFO, then overflow it.
        foreach (fill_a[i]) cycle(1'b1, 1'b0, fill_a[i], $sformatf("fill%0d", i));
        cycle(1'b1, 1'b0, 2'b10, "overflow");
        cycle(1'b0, 1'b0, 2'b00, "overflow_hold");

        // Drain, then push and pop one word to show the pointers wrap.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'b00, $sformatf("drain%0d", i));
        cycle(1'b0, 1'b0, 2'b00, "valid_drop");
        cycle(1'b1, 1'b0, 2'b11, "wrap_push");
        cycle(1'b0, 1'b1, 2'b00, "wrap_pop");

        // Push and pop in the same cycle while the FIFO is full.
        cycle(1'b1, 1'b0, 2'b01, "pre_reset_push");
        do_reset("rst_mid");
        foreach (fill_b[i]) cycle(1'b1, 1'b0, fill_b[i], $sformatf("fillb%0d", i));
        cycle(1'b1, 1'b1, 2'b10, "full_simul");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'b00, $sformatf("drainb%0d", i));

        // Underflow on empty while a push is accepted in the same cycle.
        cycle(1'b1, 1'b1, 2'b01, "empty_simul");
        cycle(1'b0, 1'b1, 2'b00, "empty_simul_pop");
        cycle(1'b0, 1'b1, 2'b00, "underflow");
        cycle(1'b1, 1'b0, 2'b10, "pre_reset2");
        do_reset("rst_nonempty");
        cycle(1'b1, 1'b0, 2'b11, "after_rst_push");
        cycle(1'b0, 1'b1, 2'b00, "after_rst_pop");

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($sformatf("rnd_rst%0d", i));
            end else begin
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      data_t'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
